// File: rtl/cuckoo_hash_engine.sv
// Two-table cuckoo hash store with a clocked insert/evict chain.
// Lookup, insert, delete and clear-all over a valid/ready request/response handshake.
module cuckoo_hash_engine #(
  parameter int KEY_W     = 8,
  parameter int ADDR_W    = 3,
  parameter int MAX_KICKS = 20,
  parameter int CNT_W     = ADDR_W + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [KEY_W-1:0]  req_key,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [1:0]        resp_status,
  output logic [KEY_W-1:0]  resp_key,
  output logic [7:0]        resp_kicks,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int               DEPTH    = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] OCC_MAX  = CNT_W'(2 * DEPTH);
  localparam logic [7:0]       KICK_LIM = 8'(MAX_KICKS);

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_HIT  = 2'b01;
  localparam logic [1:0] ST_MISS = 2'b10;
  localparam logic [1:0] ST_FAIL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_KICK, S_RESP} state_t;

  function automatic logic [ADDR_W-1:0] h0(input logic [KEY_W-1:0] k);
    return k[ADDR_W-1:0];
  endfunction

  // Key bits above KEY_W read as zero via the sized cast.
  function automatic logic [ADDR_W-1:0] h1(input logic [KEY_W-1:0] k);
    logic [2*ADDR_W-1:0] kx;
    kx = (2*ADDR_W)'(k);
    return (~kx[ADDR_W-1:0]) ^ kx[2*ADDR_W-1:ADDR_W];
  endfunction

  function automatic logic [CNT_W-1:0] occ_inc(input logic [CNT_W-1:0] c);
    return (c == OCC_MAX) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [CNT_W-1:0] occ_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d, status_q, status_d;
  logic [KEY_W-1:0]   key_q, key_d, hand_q, hand_d, rkey_q, rkey_d;
  logic [7:0]         kicks_q, kicks_d;
  logic               side_q, side_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic [KEY_W-1:0]   t0_q [DEPTH];
  logic [KEY_W-1:0]   t0_d [DEPTH];
  logic [KEY_W-1:0]   t1_q [DEPTH];
  logic [KEY_W-1:0]   t1_d [DEPTH];

  logic [ADDR_W-1:0]  p0_s, p1_s, tgt_idx_s, nxt_idx_s;
  logic [KEY_W-1:0]   victim_s;
  logic               nxt_free_s;
  logic [7:0]         kicks_inc_s;

  assign p0_s        = h0(key_q);
  assign p1_s        = h1(key_q);
  assign tgt_idx_s   = side_q ? h1(hand_q) : h0(hand_q);
  assign victim_s    = side_q ? t1_q[tgt_idx_s] : t0_q[tgt_idx_s];
  // The evicted key always lands in the table opposite the one written this cycle.
  assign nxt_idx_s   = side_q ? h0(victim_s) : h1(victim_s);
  assign nxt_free_s  = side_q ? (t0_q[nxt_idx_s] == '0) : (t1_q[nxt_idx_s] == '0);
  assign kicks_inc_s = kicks_q + 8'd1;

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_status = status_q;
  assign resp_key    = rkey_q;
  assign resp_kicks  = kicks_q;
  assign occupancy   = occ_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    key_d    = key_q;
    hand_d   = hand_q;
    kicks_d  = kicks_q;
    side_d   = side_q;
    occ_d    = occ_q;
    status_d = status_q;
    rkey_d   = rkey_q;
    t0_d     = t0_q;
    t1_d     = t1_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          key_d   = req_key;
          hand_d  = req_key;
          kicks_d = 8'd0;
          state_d = S_PROBE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PROBE: begin
        state_d = S_RESP;
        rkey_d  = key_q;
        if (op_q == OP_CLEAR) begin
          for (int i = 0; i < DEPTH; i++) begin
            t0_d[i] = '0;
            t1_d[i] = '0;
          end
          occ_d    = '0;
          status_d = ST_OK;
        end else if (key_q == '0) begin
          status_d = ST_FAIL;
        end else begin
          case (op_q)
            OP_LOOKUP: status_d = ((t0_q[p0_s] == key_q) || (t1_q[p1_s] == key_q)) ? ST_HIT : ST_MISS;
            OP_DELETE: begin
              if (t0_q[p0_s] == key_q) begin
                t0_d[p0_s] = '0;
                occ_d      = occ_dec(occ_q);
                status_d   = ST_HIT;
              end else if (t1_q[p1_s] == key_q) begin
                t1_d[p1_s] = '0;
                occ_d      = occ_dec(occ_q);
                status_d   = ST_HIT;
              end else begin
                status_d = ST_MISS;
              end
            end
            OP_INSERT: begin
              if ((t0_q[p0_s] == key_q) || (t1_q[p1_s] == key_q)) begin
                status_d = ST_HIT;
              end else if (t0_q[p0_s] == '0) begin
                t0_d[p0_s] = key_q;
                occ_d      = occ_inc(occ_q);
                status_d   = ST_OK;
              end else if (t1_q[p1_s] == '0) begin
                t1_d[p1_s] = key_q;
                occ_d      = occ_inc(occ_q);
                status_d   = ST_OK;
              end else begin
                side_d  = 1'b0;
                state_d = S_KICK;
              end
            end
            default: status_d = ST_FAIL;
          endcase
        end
      end
      S_KICK: begin
        if (side_q) begin
          t1_d[tgt_idx_s] = hand_q;
        end else begin
          t0_d[tgt_idx_s] = hand_q;
        end
        hand_d  = victim_s;
        kicks_d = kicks_inc_s;
        side_d  = ~side_q;
        if (nxt_free_s) begin
          if (side_q) begin
            t0_d[nxt_idx_s] = victim_s;
          end else begin
            t1_d[nxt_idx_s] = victim_s;
          end
          occ_d    = occ_inc(occ_q);
          status_d = ST_OK;
          rkey_d   = key_q;
          state_d  = S_RESP;
        end else if (kicks_inc_s == KICK_LIM) begin
          status_d = ST_FAIL;
          rkey_d   = victim_s;
          state_d  = S_RESP;
        end else begin
          state_d = S_KICK;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      key_q    <= '0;
      hand_q   <= '0;
      kicks_q  <= 8'd0;
      side_q   <= 1'b0;
      occ_q    <= '0;
      status_q <= 2'b00;
      rkey_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        t0_q[i] <= '0;
        t1_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      key_q    <= key_d;
      hand_q   <= hand_d;
      kicks_q  <= kicks_d;
      side_q   <= side_d;
      occ_q    <= occ_d;
      status_q <= status_d;
      rkey_q   <= rkey_d;
      t0_q     <= t0_d;
      t1_q     <= t1_d;
    end
  end

endmodule

// File: tb/tb_cuckoo_hash_engine.sv
// Scoreboard bench for cuckoo_hash_engine, built with MAX_KICKS=4 so eviction failure is reachable.
module tb_cuckoo_hash_engine;

  localparam logic [1:0] OP_LK = 2'b00;
  localparam logic [1:0] OP_IN = 2'b01;
  localparam logic [1:0] OP_DL = 2'b10;
  localparam logic [1:0] OP_CL = 2'b11;
  localparam logic [1:0] S_OK   = 2'b00;
  localparam logic [1:0] S_HIT  = 2'b01;
  localparam logic [1:0] S_MISS = 2'b10;
  localparam logic [1:0] S_FAIL = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0] req_op, resp_status;
  logic [7:0] req_key, resp_key, resp_kicks;
  logic [4:0] occupancy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] st;
    logic [7:0] key;
    logic [7:0] kicks;
    logic [4:0] occ;
    int         lat;
  } exp_t;
  exp_t sb_q[$];

  cuckoo_hash_engine #(.KEY_W(8), .ADDR_W(3), .MAX_KICKS(4), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
    .resp_key(resp_key), .resp_kicks(resp_kicks), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_req(input logic [1:0] op, input logic [7:0] key,
                        input logic [1:0] st, input logic [7:0] rkey, input logic [7:0] kk,
                        input logic [4:0] occ, input int lat, input int hold);
    exp_t e;
    exp_t g;
    int   n;
    e.st = st; e.key = rkey; e.kicks = kk; e.occ = occ; e.lat = lat;
    sb_q.push_back(e);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_key = key; resp_ready = 1'b0;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!resp_valid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    g = sb_q.pop_front();
    chk_eq("resp_valid", 32'(resp_valid), 32'd1);
    chk_eq("latency", 32'(n), 32'(g.lat));
    chk_eq("status", 32'(resp_status), 32'(g.st));
    chk_eq("resp_key", 32'(resp_key), 32'(g.key));
    chk_eq("kicks", 32'(resp_kicks), 32'(g.kicks));
    chk_eq("occupancy", 32'(occupancy), 32'(g.occ));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk_eq("stall_valid", 32'(resp_valid), 32'd1);
      chk_eq("stall_ready", 32'(req_ready), 32'd0);
      chk_eq("stall_status", 32'(resp_status), 32'(g.st));
      chk_eq("stall_key", 32'(resp_key), 32'(g.key));
      chk_eq("stall_kicks", 32'(resp_kicks), 32'(g.kicks));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk_eq("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_key = 8'h00; resp_ready = 1'b0;
    apply_reset();
    chk_eq("rst_req_ready", 32'(req_ready), 32'd1);
    chk_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk_eq("rst_status", 32'(resp_status), 32'd0);
    chk_eq("rst_key", 32'(resp_key), 32'd0);
    chk_eq("rst_kicks", 32'(resp_kicks), 32'd0);
    chk_eq("rst_occ", 32'(occupancy), 32'd0);

    do_req(OP_LK, 8'h05, S_MISS, 8'h05, 8'd0, 5'd0, 2, 0);
    do_req(OP_IN, 8'h01, S_OK,   8'h01, 8'd0, 5'd1, 2, 0);
    do_req(OP_IN, 8'h09, S_OK,   8'h09, 8'd0, 5'd2, 2, 0);
    do_req(OP_IN, 8'h01, S_HIT,  8'h01, 8'd0, 5'd2, 2, 0);
    do_req(OP_IN, 8'h49, S_OK,   8'h49, 8'd1, 5'd3, 3, 0);
    do_req(OP_LK, 8'h49, S_HIT,  8'h49, 8'd0, 5'd3, 2, 0);
    do_req(OP_LK, 8'h01, S_HIT,  8'h01, 8'd0, 5'd3, 2, 0);
    do_req(OP_LK, 8'h09, S_HIT,  8'h09, 8'd0, 5'd3, 2, 0);

    apply_reset();
    do_req(OP_IN, 8'h09, S_OK,   8'h09, 8'd0, 5'd1, 2, 0);
    do_req(OP_IN, 8'h49, S_OK,   8'h49, 8'd0, 5'd2, 2, 0);
    do_req(OP_IN, 8'h89, S_FAIL, 8'h09, 8'd4, 5'd2, 6, 0);
    do_req(OP_LK, 8'h09, S_MISS, 8'h09, 8'd0, 5'd2, 2, 0);
    do_req(OP_LK, 8'h49, S_HIT,  8'h49, 8'd0, 5'd2, 2, 0);
    do_req(OP_LK, 8'h89, S_HIT,  8'h89, 8'd0, 5'd2, 2, 0);

    do_req(OP_DL, 8'h49, S_HIT,  8'h49, 8'd0, 5'd1, 2, 0);
    do_req(OP_DL, 8'h49, S_MISS, 8'h49, 8'd0, 5'd1, 2, 0);
    do_req(OP_IN, 8'h00, S_FAIL, 8'h00, 8'd0, 5'd1, 2, 0);
    do_req(OP_LK, 8'h00, S_FAIL, 8'h00, 8'd0, 5'd1, 2, 0);
    do_req(OP_LK, 8'h89, S_HIT,  8'h89, 8'd0, 5'd1, 2, 5);
    do_req(OP_CL, 8'h00, S_OK,   8'h00, 8'd0, 5'd0, 2, 0);
    do_req(OP_LK, 8'h89, S_MISS, 8'h89, 8'd0, 5'd0, 2, 0);

    // Reset lands while the engine is mid-chain.
    do_req(OP_IN, 8'h09, S_OK,   8'h09, 8'd0, 5'd1, 2, 0);
    do_req(OP_IN, 8'h49, S_OK,   8'h49, 8'd0, 5'd2, 2, 0);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_IN; req_key = 8'h89;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_eq("kick_busy", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_eq("midrst_ready", 32'(req_ready), 32'd1);
    chk_eq("midrst_valid", 32'(resp_valid), 32'd0);
    chk_eq("midrst_occ", 32'(occupancy), 32'd0);
    do_req(OP_LK, 8'h09, S_MISS, 8'h09, 8'd0, 5'd0, 2, 0);
    do_req(OP_LK, 8'h49, S_MISS, 8'h49, 8'd0, 5'd0, 2, 0);
    do_req(OP_LK, 8'h89, S_MISS, 8'h89, 8'd0, 5'd0, 2, 0);

    chk_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
